// File: rtl/dpram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM port arbiter and the
// reusable round-robin core.
package dpram_arb_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;
    localparam int MAX_REQ    = 4;
    localparam int LOCK_CNT_W = 5;

    typedef logic [MAX_REQ-1:0]         req_vec_t;
    typedef logic [$clog2(MAX_REQ)-1:0] req_idx_t;
    typedef logic [LOCK_CNT_W-1:0]      lock_cnt_t;

    // One-hot grant: first active requester found searching upward from ptr,
    // wrapping modulo num_req.
    function automatic req_vec_t rr_pick(input req_vec_t    req,
                                         input req_idx_t    ptr,
                                         input int unsigned num_req);
        req_vec_t gnt;
        logic     found;
        req_idx_t idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = req_idx_t'((32'(ptr) + k) % num_req);
            if (k < num_req && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

    // Index of the set bit of a one-hot vector (0 when empty).
    function automatic req_idx_t onehot_to_idx(input req_vec_t v);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (v[i]) idx = req_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter core: combinational rotating-priority grant plus the
// rotation pointer. An optional hold input pins the grant to one requester.
module rr_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               hold_en,
    input  req_idx_t           hold_idx,
    output logic [NUM_REQ-1:0] gnt,
    output req_idx_t           gnt_idx
);

    req_vec_t req_ext;
    req_vec_t gnt_full;
    req_idx_t ptr;
    req_idx_t ptr_next;

    // Grant the pinned holder if any, otherwise rotate from ptr.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        if (hold_en) gnt_full  = req_vec_t'(1) << hold_idx;
        else         gnt_full  = rr_pick(req_ext, ptr, NUM_REQ);
        gnt      = gnt_full[NUM_REQ-1:0];
        gnt_idx  = onehot_to_idx(gnt_full);
        ptr_next = (gnt_idx == req_idx_t'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Priority moves just past whoever was served; holds when idle.
    // NOTE: non-blocking assignment keeps every register sampling pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  ptr <= '0;
        else if (|req) ptr <= ptr_next;
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM port of the 8192x32 dual-port RAM
// between NUM_REQ masters. Reads return exactly one cycle after acceptance.
// Optional grant locking is built when ARB_LOCK_EN is defined.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BE_W     = DEF_BE_W,
    parameter int MAX_LOCK = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_read,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*BE_W-1:0]  req_byteenable,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    input  logic [NUM_REQ-1:0]       req_lock,
    output logic [NUM_REQ-1:0]       req_waitrequest,
    output logic [DATA_W-1:0]        req_readdata,
    output logic [NUM_REQ-1:0]       req_readdatavalid,
    output logic                     mem_chipselect,
    output logic                     mem_write,
    output logic                     mem_clken,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [BE_W-1:0]          mem_byteenable,
    output logic [DATA_W-1:0]        mem_writedata,
    input  logic [DATA_W-1:0]        mem_readdata
);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rd_tag;
    req_idx_t           gnt_idx;
    req_vec_t           wr_ext;
    logic               any_req;
    logic               hold_en;
    req_idx_t           hold_idx;

    assign req     = req_read | req_write;
    assign any_req = |req;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .hold_en  (hold_en),
        .hold_idx (hold_idx),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    // Route the granted requester onto the RAM port; idle port drives zeros.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ext               = '0;
        wr_ext[NUM_REQ-1:0]  = req_write;
        mem_chipselect       = any_req;
        mem_write            = 1'b0;
        mem_address          = '0;
        mem_byteenable       = '0;
        mem_writedata        = '0;
        if (any_req) begin
            mem_write      = wr_ext[gnt_idx];
            mem_address    = req_address[32'(gnt_idx)*ADDR_W +: ADDR_W];
            mem_byteenable = req_byteenable[32'(gnt_idx)*BE_W +: BE_W];
            mem_writedata  = req_writedata[32'(gnt_idx)*DATA_W +: DATA_W];
        end
    end

    assign mem_clken         = 1'b1;
    assign req_waitrequest   = req & ~gnt;
    assign req_readdata      = mem_readdata;
    assign req_readdatavalid = rd_tag;

    // Tag the accepted read so its data is steered back next cycle; a write
    // wins over a simultaneous read strobe and returns nothing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_tag <= '0;
        else          rd_tag <= gnt & req_read & ~req_write;
    end

`ifdef ARB_LOCK_EN
    logic      owner_vld;
    logic      owner_active;
    req_idx_t  owner_idx;
    lock_cnt_t lock_cnt;
    lock_cnt_t cnt_next;
    req_vec_t  req_ext;
    req_vec_t  lock_ext;

    // The owner keeps the grant only while it is still requesting.
    always_comb begin
        req_ext               = '0;
        req_ext[NUM_REQ-1:0]  = req;
        lock_ext              = '0;
        lock_ext[NUM_REQ-1:0] = req_lock;
        owner_active          = owner_vld & req_ext[owner_idx];
        cnt_next              = lock_cnt + 1'b1;
    end

    assign hold_en  = owner_active;
    assign hold_idx = owner_idx;

    // Ownership: taken on a locked access, dropped on idle, unlock or burst limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_vld <= 1'b0;
            owner_idx <= '0;
            lock_cnt  <= '0;
        end else if (owner_active) begin
            if (!lock_ext[owner_idx] || cnt_next >= lock_cnt_t'(MAX_LOCK))
                owner_vld <= 1'b0;
            else
                lock_cnt  <= cnt_next;
        end else if (any_req && lock_ext[gnt_idx] && MAX_LOCK > 1) begin
            owner_vld <= 1'b1;
            owner_idx <= gnt_idx;
            lock_cnt  <= lock_cnt_t'(1);
        end else begin
            owner_vld <= 1'b0;
        end
    end
`else
    logic lock_unused;
    assign lock_unused = ^req_lock;
    assign hold_en     = 1'b0;
    assign hold_idx    = '0;
`endif

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Round-robin arbiter sharing one Avalon-MM port of the on-chip dual-port RAM (8192 x 32, byte-enabled) between NUM_REQ masters.
- RAM address/data/byteenable are registered inside the RAM on clk; q is unregistered, so read data is valid exactly one cycle after issue.
- The arbiter adds waitrequest and readdatavalid toward requesters and drives the RAM port's chipselect, write, clken, address, byteenable and writedata.

Parameters:
- NUM_REQ, 2, number of requesting masters (2..4).
- ADDR_W, 13, word address width.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- MAX_LOCK, 16, maximum consecutive cycles a locked requester may hold the grant.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_read  in  NUM_REQ  per-requester read strobe.
- req_write  in  NUM_REQ  per-requester write strobe.
- req_address  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_byteenable  in  NUM_REQ*BE_W  flattened byteenables.
- req_writedata  in  NUM_REQ*DATA_W  flattened write data.
- req_lock  in  NUM_REQ  hold grant after the current access (active only when ARB_LOCK_EN is defined).
- req_waitrequest  out  NUM_REQ  request not accepted this cycle.
- req_readdata  out  DATA_W  shared read data bus.
- req_readdatavalid  out  NUM_REQ  one-hot; read data on req_readdata belongs to requester i.
- mem_chipselect  out  1  RAM chipselect.
- mem_write  out  1  RAM write.
- mem_clken  out  1  RAM clken; tied to 1.
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  BE_W  RAM byteenable.
- mem_writedata  out  DATA_W  RAM write data.
- mem_readdata  in  DATA_W  RAM q.

Behaviour:
- Request definition: req_i = req_read[i] | req_write[i]. If both strobes are high, the request is treated as a write.
- Grant: combinational, same cycle. Search starts at rr_ptr and proceeds upward, wrapping modulo NUM_REQ. The first active requester wins (gnt one-hot).
- RAM drive:
  - mem_chipselect = |req.
  - mem_write = the write strobe of the granted requester.
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted requester.
  - With no grant: all mem outputs are 0 except mem_clken = 1.
- Waitrequest: req_waitrequest[i] = req_i & ~gnt[i]. Non-requesting lines read 0. The granted request is accepted on the rising edge; there is no back-pressure from the RAM.
- rr_ptr update on each accepted access: rr_ptr <= (granted index + 1) mod NUM_REQ, unless the lock rule applies. With no request, rr_ptr holds.
- Read return: rd_tag <= gnt & read, registered. req_readdatavalid = rd_tag. req_readdata = mem_readdata, passed through unregistered. Latency from acceptance to readdatavalid is exactly 1 cycle.
- Back-to-back reads from one or several requesters sustain one access per cycle.
- Writes produce no response.
- Fairness: with all requesters asserting continuously and no lock, each is served within NUM_REQ-1 wait cycles.
- Reset (asynchronous assert, synchronous release):
  - rr_ptr = 0, rd_tag = 0, lock state cleared.
  - All outputs 0 except mem_clken = 1.
  - Reset mid-read: the pending readdatavalid is dropped.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - If the granted requester has req_lock high when accepted, it becomes owner. A 5-bit lock_cnt starts at 1 and increments per accepted owner access.
  - While the owner keeps requesting, it keeps the grant and the others wait.
  - Ownership ends when any of these occurs:
    - the owner drops its request;
    - the owner drops req_lock on an accepted access;
    - lock_cnt reaches MAX_LOCK.
  - On release, rr_ptr = owner + 1.
  - An owner idle for one cycle loses ownership.
- Undefined: req_lock is ignored and no lock state exists.

Decomposition:
- Package dpram_arb_pkg:
  - localparam defaults (ADDR_W, DATA_W, BE_W);
  - function rr_pick(req, ptr) returning a one-hot grant;
  - typedef for the lock counter.
- Sub-module rr_arbiter: combinational priority rotation plus the rr_ptr register. It is reused by other shared-peripheral arbiters.

Test Plan:
- Single read, req0 addr 0x0005: gnt0 same cycle, waitrequest0 = 0; readdatavalid = 2'b01 next cycle; readdata equals the hex init word at address 5.
- Simultaneous write req0 (addr 0x10, data 0xDEADBEEF, be 4'hF) and read req1 (addr 0x10) after reset:
  - req0 wins (rr_ptr = 0) and req1 waits 1 cycle;
  - req1 then reads 0xDEADBEEF with readdatavalid = 2'b10.
- Both requesters streaming 8 reads each: grants alternate 0,1,0,1; no waitrequest lasts more than 1 cycle; 16 readdatavalids arrive in issue order.
- Byte write be = 4'b0010, data 0x0000AB00, to a word holding 0x11223344: readback is 0x1122AB44.
- Assert reset_n low in the cycle after a read is accepted: readdatavalid stays 0; after release rr_ptr = 0 and all outputs are idle.
- ARB_LOCK_EN, MAX_LOCK = 4: req0 locked and streaming, req1 requesting; req0 gets 4 grants, then req1 is granted; req0 is not re-granted until after req1.
